motion_bbox_overlay: RTL

Next-generation moving-target box overlay for the frame-difference motion path. It tracks the bounding box of set pixels in the binary detection stream and rejects frames with too few pixels as noise. It holds the last valid box for a programmable number of empty frames. The box is drawn with parametrised thickness and colour onto the RGB565 camera stream, using that stream's own counters, with tear-free box updates at frame start.

---
 rtl/motion_bbox_overlay.sv | 294 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/motion_bbox_overlay.sv
// Motion bounding-box tracker with a tear-free RGB565 border overlay on the camera stream.
// Optional feature: define MOTION_BBOX_CROSSHAIR_EN to also paint a centre crosshair.
module motion_bbox_overlay #(
  parameter int          IMG_WIDTH    = 640,
  parameter int          IMG_HEIGHT   = 480,
  parameter int          CNT_W        = 11,
  parameter int          BORDER_W     = 4,
  parameter logic [15:0] BORDER_COLOR = 16'hF800,
  parameter int          MIN_PIXELS   = 16,
  parameter int          HOLD_FRAMES  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             per_frame_vsync,
  input  logic             per_frame_href,
  input  logic             per_frame_clken,
  input  logic             per_img_Y,
  input  logic             cmos_frame_vsync,
  input  logic             cmos_frame_href,
  input  logic             cmos_frame_clken,
  input  logic [15:0]      cmos_frame_data,
  output logic             post_frame_vsync,
  output logic             post_frame_href,
  output logic             post_frame_clken,
  output logic [15:0]      post_img_Y,
  output logic             box_valid,
  output logic [CNT_W-1:0] box_left,
  output logic [CNT_W-1:0] box_right,
  output logic [CNT_W-1:0] box_up,
  output logic [CNT_W-1:0] box_down
);

  localparam int               XW         = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] INIT_MIN_H = CNT_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] INIT_MIN_V = CNT_W'(IMG_HEIGHT - 1);
  localparam logic [19:0]      PIX_MAX    = '1;
  localparam logic [19:0]      MIN_PIX    = 20'(MIN_PIXELS);
  localparam logic [3:0]       HOLD_LIM   = 4'(HOLD_FRAMES);
  localparam logic [XW-1:0]    BW_M1      = XW'(BORDER_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  // Detection-stream timing
  logic             det_vsync_q;
  logic             det_href_q;
  logic [CNT_W-1:0] det_h_q;
  logic [CNT_W-1:0] det_v_q;
  logic             det_vs_rise;
  logic             det_vs_fall;
  logic             det_pix;

  // Accumulator and committed box
  state_e           state_q, state_d;
  logic [CNT_W-1:0] min_h_q, min_h_d, min_v_q, min_v_d;
  logic [CNT_W-1:0] max_h_q, max_h_d, max_v_q, max_v_d;
  logic [19:0]      pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0] box_l_q, box_l_d, box_r_q, box_r_d;
  logic [CNT_W-1:0] box_u_q, box_u_d, box_dn_q, box_dn_d;
  logic             box_valid_q, box_valid_d;
  logic [3:0]       miss_q, miss_d;

  // Display side
  logic             post_vsync_q, post_href_q, post_clken_q;
  logic [15:0]      post_pix_q, post_pix_d;
  logic [CNT_W-1:0] ch_q, cv_q;
  logic             sh_valid_q;
  logic [CNT_W-1:0] sh_l_q, sh_r_q, sh_u_q, sh_d_q;
  logic             cam_vs_rise;

  assign det_vs_rise = per_frame_vsync & ~det_vsync_q;
  assign det_vs_fall = ~per_frame_vsync & det_vsync_q;
  assign det_pix     = per_frame_clken & per_frame_href & per_img_Y;
  assign cam_vs_rise = cmos_frame_vsync & ~post_vsync_q;

  // The vsync history resets high so a reset released mid-frame cannot fake a frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      det_vsync_q <= 1'b1;
      det_href_q  <= 1'b0;
      det_h_q     <= '0;
      det_v_q     <= '0;
    end else begin
      det_vsync_q <= per_frame_vsync;
      det_href_q  <= per_frame_href;
      if (!per_frame_href)
        det_h_q <= '0;
      else if (per_frame_clken && det_h_q != CNT_MAX)
        det_h_q <= det_h_q + CNT_ONE;
      if (!per_frame_vsync)
        det_v_q <= '0;
      else if (det_href_q && !per_frame_href && det_v_q != CNT_MAX)
        det_v_q <= det_v_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      min_h_q     <= '0;
      min_v_q     <= '0;
      max_h_q     <= '0;
      max_v_q     <= '0;
      pix_cnt_q   <= '0;
      box_l_q     <= '0;
      box_r_q     <= '0;
      box_u_q     <= '0;
      box_dn_q    <= '0;
      box_valid_q <= 1'b0;
      miss_q      <= '0;
    end else begin
      state_q     <= state_d;
      min_h_q     <= min_h_d;
      min_v_q     <= min_v_d;
      max_h_q     <= max_h_d;
      max_v_q     <= max_v_d;
      pix_cnt_q   <= pix_cnt_d;
      box_l_q     <= box_l_d;
      box_r_q     <= box_r_d;
      box_u_q     <= box_u_d;
      box_dn_q    <= box_dn_d;
      box_valid_q <= box_valid_d;
      miss_q      <= miss_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    min_h_d     = min_h_q;
    min_v_d     = min_v_q;
    max_h_d     = max_h_q;
    max_v_d     = max_v_q;
    pix_cnt_d   = pix_cnt_q;
    box_l_d     = box_l_q;
    box_r_d     = box_r_q;
    box_u_d     = box_u_q;
    box_dn_d    = box_dn_q;
    box_valid_d = box_valid_q;
    miss_d      = miss_q;

    case (state_q)
      IDLE: begin
        if (det_vs_rise) begin
          state_d   = ACCUM;
          min_h_d   = INIT_MIN_H;
          min_v_d   = INIT_MIN_V;
          max_h_d   = '0;
          max_v_d   = '0;
          pix_cnt_d = '0;
        end
      end
      ACCUM: begin
        if (det_pix) begin
          if (det_h_q < min_h_q) min_h_d = det_h_q;
          if (det_h_q > max_h_q) max_h_d = det_h_q;
          if (det_v_q < min_v_q) min_v_d = det_v_q;
          if (det_v_q > max_v_q) max_v_d = det_v_q;
          if (pix_cnt_q != PIX_MAX) pix_cnt_d = pix_cnt_q + 20'd1;
        end
        if (det_vs_fall) state_d = COMMIT;
      end
      COMMIT: begin
        if (pix_cnt_q >= MIN_PIX) begin
          box_l_d     = min_h_q;
          box_r_d     = max_h_q;
          box_u_d     = min_v_q;
          box_dn_d    = max_v_q;
          box_valid_d = 1'b1;
          miss_d      = '0;
        end else if (miss_q < HOLD_LIM) begin
          miss_d = miss_q + 4'd1;
        end else begin
          box_valid_d = 1'b0;
        end
        // A back-to-back frame may start in the commit cycle itself.
        if (det_vs_rise) begin
          state_d   = ACCUM;
          min_h_d   = INIT_MIN_H;
          min_v_d   = INIT_MIN_V;
          max_h_d   = '0;
          max_v_d   = '0;
          pix_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Camera counters plus the shadow box, which only changes at camera frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q       <= '0;
      cv_q       <= '0;
      sh_valid_q <= 1'b0;
      sh_l_q     <= '0;
      sh_r_q     <= '0;
      sh_u_q     <= '0;
      sh_d_q     <= '0;
    end else begin
      if (!cmos_frame_href)
        ch_q <= '0;
      else if (cmos_frame_clken && ch_q != CNT_MAX)
        ch_q <= ch_q + CNT_ONE;
      if (!cmos_frame_vsync)
        cv_q <= '0;
      else if (post_href_q && !cmos_frame_href && cv_q != CNT_MAX)
        cv_q <= cv_q + CNT_ONE;
      if (cam_vs_rise) begin
        sh_valid_q <= box_valid_q;
        sh_l_q     <= box_l_q;
        sh_r_q     <= box_r_q;
        sh_u_q     <= box_u_q;
        sh_d_q     <= box_dn_q;
      end
    end
  end

  logic [XW-1:0] ch_x, cv_x, l_x, r_x, u_x, d_x;
  logic          in_col_l, in_col_r, in_row_u, in_row_d, v_span, h_span;
  logic          border_hit, paint;

  assign ch_x = {1'b0, ch_q};
  assign cv_x = {1'b0, cv_q};
  assign l_x  = {1'b0, sh_l_q};
  assign r_x  = {1'b0, sh_r_q};
  assign u_x  = {1'b0, sh_u_q};
  assign d_x  = {1'b0, sh_d_q};

  // One extra bit keeps the far edges of the border from wrapping back to column/row 0.
  assign in_col_l = (ch_x >= l_x) && (ch_x <= l_x + BW_M1);
  assign in_col_r = (ch_x >= r_x) && (ch_x <= r_x + BW_M1);
  assign in_row_u = (cv_x >= u_x) && (cv_x <= u_x + BW_M1);
  assign in_row_d = (cv_x >= d_x) && (cv_x <= d_x + BW_M1);
  assign v_span   = (cv_x >= u_x) && (cv_x <= d_x + BW_M1);
  assign h_span   = (ch_x >= l_x) && (ch_x <= r_x + BW_M1);

  assign border_hit = sh_valid_q &&
                      (((in_col_l || in_col_r) && v_span) ||
                       ((in_row_u || in_row_d) && h_span));

`ifdef MOTION_BBOX_CROSSHAIR_EN
  logic [XW-1:0] sum_h, sum_v, cx, cy;
  logic          cross_hit;

  assign sum_h     = l_x + r_x;
  assign sum_v     = u_x + d_x;
  assign cx        = sum_h >> 1;
  assign cy        = sum_v >> 1;
  assign cross_hit = sh_valid_q &&
                     (((ch_x == cx) && (cv_x >= u_x) && (cv_x <= d_x)) ||
                      ((cv_x == cy) && (ch_x >= l_x) && (ch_x <= r_x)));
  assign paint     = border_hit || cross_hit;
`else
  assign paint     = border_hit;
`endif

  always_comb begin
    post_pix_d = 16'h0000;
    if (cmos_frame_href && cmos_frame_clken)
      post_pix_d = paint ? BORDER_COLOR : cmos_frame_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      post_vsync_q <= 1'b0;
      post_href_q  <= 1'b0;
      post_clken_q <= 1'b0;
      post_pix_q   <= '0;
    end else begin
      post_vsync_q <= cmos_frame_vsync;
      post_href_q  <= cmos_frame_href;
      post_clken_q <= cmos_frame_clken;
      post_pix_q   <= post_pix_d;
    end
  end

  assign post_frame_vsync = post_vsync_q;
  assign post_frame_href  = post_href_q;
  assign post_frame_clken = post_clken_q;
  assign post_img_Y       = post_pix_q;
  assign box_valid        = box_valid_q;
  assign box_left         = box_l_q;
  assign box_right        = box_r_q;
  assign box_up           = box_u_q;
  assign box_down         = box_dn_q;

endmodule
